spi_memory_slave: RTL and testbench

SPI_MEMORY_SLAVE -- requirements
Module: spi_memory_slave

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_input_sync.sv | 26 ++
 rtl/spi_memory_slave.sv | 158 +++++++++++++++
 tb/tb_spi_memory_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory slave.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrite,
        StRead,
        StHold
    } spi_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Sampling happens on the rising SCLK edge exactly when CPOL equals CPHA.
    function automatic logic sample_on_rise(input int unsigned cpol, input int unsigned cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser with rise/fall edge detection for one asynchronous input.
module spi_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    // Clearing to 0 means a cs held low across reset never fakes a falling event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_memory_slave.sv
// SPI slave fronting a DEPTH x WIDTH memory; first word is {addr, rw}.
// Define SPI_BURST_EN to auto-increment the address and continue across words.
module spi_memory_slave
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CPOL  = 0,
    parameter int unsigned CPHA  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic miso_en,
    output logic busy
);

    localparam int unsigned ADDR_WIDTH = WIDTH - 1;
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_input_sync u_sync_sclk (.clk(clk), .reset(reset), .din(sclk),
                                .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_input_sync u_sync_cs   (.clk(clk), .reset(reset), .din(cs),
                                .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_input_sync u_sync_mosi (.clk(clk), .reset(reset), .din(mosi),
                                .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    logic sample_edge, drive_edge;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign drive_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   miso_q, miso_d;
    logic                   load_q, load_d;
    logic                   wr_q, wr_d;
    logic [WIDTH-1:0]       mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        addr_d    = addr_q;
        miso_d    = miso_q;
        load_d    = 1'b0;
        wr_d      = 1'b0;
`ifdef SPI_BURST_EN
        if (wr_q) addr_d = addr_q + ADDR_WIDTH'(1);
`endif
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StAddr;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            StAddr: begin
                if (sample_edge) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        // Earlier bits already hold the address; the current bit is rw.
                        addr_d    = shreg_q[ADDR_WIDTH-1:0];
                        bit_cnt_d = '0;
                        if (mosi_s == RW_READ) begin
                            state_d = StRead;
                            load_d  = 1'b1;
                        end else begin
                            state_d = StWrite;
                        end
                    end
                end
            end
            StWrite: begin
                if (sample_edge) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        wr_d      = 1'b1;
`ifndef SPI_BURST_EN
                        state_d   = StHold;
`endif
                    end
                end
            end
            StRead: begin
                if (load_q) shreg_d = mem[addr_q];
                if (drive_edge) begin
                    miso_d  = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end
                // The word ends on the master's last sample, not on our last drive.
                if (sample_edge) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SPI_BURST_EN
                        addr_d    = addr_q + ADDR_WIDTH'(1);
                        load_d    = 1'b1;
`else
                        state_d   = StHold;
`endif
                    end
                end
            end
            StHold: ;
            default: state_d = StIdle;
        endcase
        if (cs_rise) state_d = StIdle;
        if (state_d != StRead) miso_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            miso_q    <= 1'b0;
            load_q    <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            miso_q    <= miso_d;
            load_q    <= load_d;
            wr_q      <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_q) mem[addr_q] <= shreg_q;
    end

    // Gating with the raw cs keeps the pad quiet the instant cs deasserts.
    assign miso_en = (state_q == StRead) && !cs;
    assign miso    = miso_en & miso_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_memory_slave.sv
// Directed bench: mode-0 DUT for the main tests and a mode-3 DUT for the repeat run.
module tb_spi_memory_slave;

    logic clk = 1'b0;
    logic reset;
    logic sclk_m = 1'b0;
    logic cs_m = 1'b1;
    logic mosi_m = 1'b0;
    logic mode = 1'b0;

    logic sclk_a, cs_a, miso_a, miso_en_a, busy_a;
    logic sclk_b, cs_b, miso_b, miso_en_b, busy_b;
    logic miso_m, miso_en_m;

    int n_checks = 0;
    int n_fail = 0;

`ifdef SPI_BURST_EN
    localparam logic HOLD_EN = 1'b1;
    localparam logic [7:0] ADDR0_EXP = 8'h22;
`else
    localparam logic HOLD_EN = 1'b0;
    localparam logic [7:0] ADDR0_EXP = 8'h5A;
`endif

    always #5 clk = ~clk;

    assign sclk_a    = mode ? 1'b0 : sclk_m;
    assign cs_a      = mode ? 1'b1 : cs_m;
    assign sclk_b    = mode ? sclk_m : 1'b1;
    assign cs_b      = mode ? cs_m : 1'b1;
    assign miso_m    = mode ? miso_b : miso_a;
    assign miso_en_m = mode ? miso_en_b : miso_en_a;

    spi_memory_slave #(.WIDTH(8), .CPOL(0), .CPHA(0)) u_dut_m0 (
        .clk(clk), .reset(reset), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_m),
        .miso(miso_a), .miso_en(miso_en_a), .busy(busy_a)
    );

    spi_memory_slave #(.WIDTH(8), .CPOL(1), .CPHA(1)) u_dut_m3 (
        .clk(clk), .reset(reset), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_m),
        .miso(miso_b), .miso_en(miso_en_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mode 0: data set, then rising sample edge. Mode 3: falling drive edge, then rising sample.
    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                             output logic en_any);
        rx = '0;
        en_any = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mode) begin
                sclk_m = 1'b0;
                mosi_m = tx[7-i];
                #80;
                sclk_m = 1'b1;
                rx = {rx[6:0], miso_m};
                en_any |= miso_en_m;
                #80;
            end else begin
                mosi_m = tx[7-i];
                #80;
                sclk_m = 1'b1;
                rx = {rx[6:0], miso_m};
                en_any |= miso_en_m;
                #80;
                sclk_m = 1'b0;
            end
        end
    endtask

    task automatic cs_low();
        cs_m = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80;
        cs_m = 1'b1;
    endtask

    task automatic wr_txn(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] rx;
        logic en;
        cs_low();
        xfer_bits(cmd, 8, rx, en);
        xfer_bits(data, 8, rx, en);
        cs_high();
        #160;
    endtask

    task automatic rd_txn(input logic [7:0] cmd, output logic [7:0] data, output logic cmd_en,
                          output logic hold_en);
        logic [7:0] rx;
        logic en;
        cs_low();
        xfer_bits(cmd, 8, rx, cmd_en);
        xfer_bits(8'h00, 8, data, en);
        #40;
        hold_en = miso_en_m;
        cs_high();
        #160;
    endtask

    initial begin
        logic [7:0] rx;
        logic en, hen;

        reset = 1'b1;
        #33;
        check_eq("rst_miso", {31'd0, miso_a}, 32'd0);
        check_eq("rst_miso_en", {31'd0, miso_en_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_busy_m3", {31'd0, busy_b}, 32'd0);
        check_eq("rst_miso_en_m3", {31'd0, miso_en_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #200;

        // Write 0xA5 to 0x12, read it back.
        cs_low();
        xfer_bits(8'h24, 8, rx, en);
        check_eq("wr_cmd_en", {31'd0, en}, 32'd0);
        xfer_bits(8'hA5, 8, rx, en);
        check_eq("wr_busy_after_word", {31'd0, busy_a}, 32'd1);
        cs_high();
        #160;
        check_eq("wr_idle_busy", {31'd0, busy_a}, 32'd0);
        rd_txn(8'h25, rx, en, hen);
        check_eq("rd12_cmd_en", {31'd0, en}, 32'd0);
        check_eq("rd12_data", {24'd0, rx}, 32'h0000_00A5);
        check_eq("rd12_hold_en", {31'd0, hen}, {31'd0, HOLD_EN});

        // Another pattern at 0x2A.
        wr_txn(8'h54, 8'h3C);
        rd_txn(8'h55, rx, en, hen);
        check_eq("rd2a_data", {24'd0, rx}, 32'h0000_003C);

        // Partial write must be discarded.
        wr_txn(8'h60, 8'h00);
        cs_low();
        xfer_bits(8'h60, 8, rx, en);
        xfer_bits(8'hFF, 5, rx, en);
        cs_high();
        repeat (4) @(posedge clk);
        #1;
        check_eq("partial_busy_4clk", {31'd0, busy_a}, 32'd0);
        #160;
        rd_txn(8'h61, rx, en, hen);
        check_eq("partial_mem30", {24'd0, rx}, 32'h0000_0000);

        // Two data words at 0x7F: burst wraps to 0x00, single-word build ignores the second.
        wr_txn(8'h00, 8'h5A);
        cs_low();
        xfer_bits(8'hFE, 8, rx, en);
        xfer_bits(8'h11, 8, rx, en);
        #40;
        check_eq("burst_busy_w1", {31'd0, busy_a}, 32'd1);
        xfer_bits(8'h22, 8, rx, en);
        #40;
        check_eq("burst_busy_w2", {31'd0, busy_a}, 32'd1);
        cs_high();
        #160;
        rd_txn(8'hFF, rx, en, hen);
        check_eq("burst_mem7f", {24'd0, rx}, 32'h0000_0011);
        rd_txn(8'h01, rx, en, hen);
        check_eq("burst_mem00", {24'd0, rx}, {24'd0, ADDR0_EXP});

        // Reset in the middle of a read data word.
        cs_low();
        xfer_bits(8'h25, 8, rx, en);
        xfer_bits(8'h00, 3, rx, en);
        #40;
        check_eq("mid_read_en", {31'd0, miso_en_a}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("arst_miso", {31'd0, miso_a}, 32'd0);
        check_eq("arst_miso_en", {31'd0, miso_en_a}, 32'd0);
        check_eq("arst_busy", {31'd0, busy_a}, 32'd0);
        cs_m = 1'b1;
        #100;
        reset = 1'b0;
        #200;
        rd_txn(8'h25, rx, en, hen);
        check_eq("post_rst_rd12", {24'd0, rx}, 32'h0000_00A5);

        // Same write/read on the CPOL=1, CPHA=1 instance.
        sclk_m = 1'b1;
        mode = 1'b1;
        #200;
        cs_low();
        xfer_bits(8'h24, 8, rx, en);
        check_eq("m3_wr_cmd_en", {31'd0, en}, 32'd0);
        xfer_bits(8'hA5, 8, rx, en);
        cs_high();
        #160;
        check_eq("m3_idle_busy", {31'd0, busy_b}, 32'd0);
        rd_txn(8'h25, rx, en, hen);
        check_eq("m3_rd_cmd_en", {31'd0, en}, 32'd0);
        check_eq("m3_rd12_data", {24'd0, rx}, 32'h0000_00A5);
        check_eq("m3_busy_a_idle", {31'd0, busy_a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
